// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified memory port arbiter.
// FSM states and transaction owner.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam int CNT_W = 3;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// arb_starve_counter: counts data grants made while fetch waits.
// Ports: CLK, reset, if_req, d_grant, if_grant in; force_if out.
module arb_starve_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic CLK,
  input  logic reset,
  input  logic if_req,
  input  logic d_grant,
  input  logic if_grant,
  output logic force_if
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt <= '0;
    end else if (if_grant) begin
      cnt <= '0;
    end else if (d_grant && if_req) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign force_if = if_req && (cnt == CNT_W'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data.
// Ports: CLK/reset, if_* fetch port, d_* data port, mem_* memory side.
// Build option ARB_STARVE_GUARD_EN: bounded data priority over fetch.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_rvalid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  logic   we_q;
  logic   grant_d, grant_if;
  logic   force_if;

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_counter #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .CLK     (CLK),
    .reset   (reset),
    .if_req  (if_req),
    .d_grant (grant_d),
    .if_grant(grant_if),
    .force_if(force_if)
  );
`else
  assign force_if = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    grant_d  = 1'b0;
    grant_if = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req && !force_if) begin
          grant_d = 1'b1;
          owner_d = OWN_D;
          state_d = BUSY;
        end else if (if_req) begin
          grant_if = 1'b1;
          owner_d  = OWN_IF;
          state_d  = BUSY;
        end
      end
      BUSY:    if (mem_ack) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_IF;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      if (grant_d) begin
        mem_addr  <= d_addr;
        we_q      <= d_we;
        mem_wdata <= d_wdata;
      end else if (grant_if) begin
        mem_addr  <= if_addr;
        we_q      <= 1'b0;
        mem_wdata <= '0;
      end
      if (state_q == BUSY && mem_ack) begin
        if (owner_q == OWN_D && !we_q)
          d_rdata <= mem_rdata;
        // Registered address picks the 32-bit half, immune to if_addr churn.
        if (owner_q == OWN_IF)
          if_rdata <= mem_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
      end
    end
  end

  assign mem_req   = (state_q == BUSY);
  assign mem_we    = mem_req && we_q;
  assign if_rvalid = (state_q == RESP) && (owner_q == OWN_IF);
  assign d_done    = (state_q == RESP) && (owner_q == OWN_D);
  assign if_stall  = if_req && !if_rvalid;
  assign d_stall   = d_req && !d_done;

endmodule
